// File: rtl/cursor_pkg.sv
// Shared types and helpers for the cursor tracker: delta/step types,
// acceleration tiers, step scaling, clamping and board-cell lookup.
package cursor_pkg;

    typedef logic signed [8:0] delta_t;
    typedef logic [8:0]        mag_t;
    typedef logic [10:0]       step_t;

    typedef enum logic [1:0] {
        TIER_1X,
        TIER_2X,
        TIER_4X
    } tier_e;

    localparam int CALC_W = 16;
    typedef logic signed [CALC_W-1:0] calc_t;

    localparam logic [1:0] OUTSIDE = 2'd3;

    // -256 negates to 9'h100, which reads back as 256 when treated unsigned
    function automatic mag_t abs_delta(input delta_t d);
        return d[8] ? mag_t'(-d) : mag_t'(d);
    endfunction

    function automatic tier_e tier_of(input mag_t m, input mag_t t1, input mag_t t2);
        if (m < t1)      return TIER_1X;
        else if (m < t2) return TIER_2X;
        else             return TIER_4X;
    endfunction

    function automatic step_t scale_step(input mag_t m, input tier_e t);
        unique case (t)
            TIER_1X: return {2'b00, m};
            TIER_2X: return {1'b0, m, 1'b0};
            TIER_4X: return {m, 2'b00};
            default: return {2'b00, m};
        endcase
    endfunction

    function automatic calc_t clamp(input calc_t v, input calc_t hi);
        if (v < 0)       return '0;
        else if (v > hi) return hi;
        else             return v;
    endfunction

    function automatic logic [1:0] cell_of(input calc_t v, input calc_t origin, input calc_t size);
        if (v < origin)                      return OUTSIDE;
        else if (v < origin + size)          return 2'd0;
        else if (v < origin + size + size)   return 2'd1;
        else if (v < origin + size + size + size) return 2'd2;
        else                                 return OUTSIDE;
    endfunction

endpackage

// File: rtl/cursor_tracker_if.sv
// Movement-packet input and cursor-state output bundle for cursor_tracker.
// Grid-cell signals exist only when CURSOR_GRID_EN is defined.
interface cursor_tracker_if
    import cursor_pkg::*;
#(
    parameter int POS_W = 10
);
    logic             mv_valid;
    delta_t           dx;
    delta_t           dy;
    logic [2:0]       btn_in;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic [2:0]       btn;
    logic             pos_upd;
    logic             click_l;
`ifdef CURSOR_GRID_EN
    logic [1:0]       cell_col;
    logic [1:0]       cell_row;
    logic             cell_vld;

    modport master (
        output mv_valid, dx, dy, btn_in,
        input  pos_x, pos_y, btn, pos_upd, click_l, cell_col, cell_row, cell_vld
    );
    modport slave (
        input  mv_valid, dx, dy, btn_in,
        output pos_x, pos_y, btn, pos_upd, click_l, cell_col, cell_row, cell_vld
    );
`else
    modport master (
        output mv_valid, dx, dy, btn_in,
        input  pos_x, pos_y, btn, pos_upd, click_l
    );
    modport slave (
        input  mv_valid, dx, dy, btn_in,
        output pos_x, pos_y, btn, pos_upd, click_l
    );
`endif
endinterface

// File: rtl/cursor_axis.sv
// One cursor axis: stage 1 registers scaled step and sign, stage 2 applies
// it to the position with saturation at 0 and MAX. INV=1 flips direction.
module cursor_axis
    import cursor_pkg::*;
#(
    parameter int POS_W  = 10,
    parameter int MAX    = 630,
    parameter int INIT   = 20,
    parameter int ACC_T1 = 8,
    parameter int ACC_T2 = 64,
    parameter int INV    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mv_valid,
    input  delta_t           d,
    output logic [POS_W-1:0] pos
);
    typedef logic signed [POS_W+2:0] sum_t;

    logic  s1_vld;
    logic  s1_neg;
    step_t s1_step;
    mag_t  mag;
    logic  sub;
    sum_t  pos_s;
    sum_t  step_s;
    sum_t  sum;
    logic [POS_W-1:0] pos_next;

    always_comb begin
        mag      = abs_delta(d);
        sub      = (INV != 0) ? ~s1_neg : s1_neg;
        pos_s    = sum_t'({3'b000, pos});
        step_s   = sum_t'(s1_step);
        sum      = sub ? (pos_s - step_s) : (pos_s + step_s);
        pos_next = POS_W'(clamp(calc_t'(sum), calc_t'(MAX)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_neg  <= 1'b0;
            s1_step <= '0;
            pos     <= POS_W'(INIT);
        end else begin
            s1_vld <= mv_valid;
            if (mv_valid) begin
                s1_neg  <= d[8];
                s1_step <= scale_step(mag, tier_of(mag, mag_t'(ACC_T1), mag_t'(ACC_T2)));
            end
            if (s1_vld)
                pos <= pos_next;
        end
    end
endmodule

// File: rtl/cursor_tracker.sv
// Cursor-position engine: PS/2 movement packets in, clamped cursor position,
// registered buttons and left-click edge out, two cycles after mv_valid.
// Define CURSOR_GRID_EN to add the 3x3 board-cell outputs.
module cursor_tracker
    import cursor_pkg::*;
#(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int CUR_W  = 10,
    parameter int CUR_H  = 5,
    parameter int X_INIT = 20,
    parameter int Y_INIT = 240,
    parameter int ACC_T1 = 8,
    parameter int ACC_T2 = 64,
    parameter int POS_W  = 10
`ifdef CURSOR_GRID_EN
    ,
    parameter int GRID_X0 = 170,
    parameter int GRID_Y0 = 90,
    parameter int CELL_W  = 100,
    parameter int CELL_H  = 100
`endif
) (
    input logic             clk,
    input logic             reset,
    cursor_tracker_if.slave bus
);
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic             s1_vld;
    logic [2:0]       s1_btn;
    logic [2:0]       btn_q;
    logic             pos_upd_q;
    logic             click_q;

    cursor_axis #(
        .POS_W(POS_W), .MAX(H_RES - CUR_W), .INIT(X_INIT),
        .ACC_T1(ACC_T1), .ACC_T2(ACC_T2), .INV(0)
    ) u_axis_x (
        .clk(clk), .reset(reset), .mv_valid(bus.mv_valid), .d(bus.dx), .pos(pos_x)
    );

    // Y grows downward on screen while PS/2 dy is positive upward
    cursor_axis #(
        .POS_W(POS_W), .MAX(V_RES - CUR_H), .INIT(Y_INIT),
        .ACC_T1(ACC_T1), .ACC_T2(ACC_T2), .INV(1)
    ) u_axis_y (
        .clk(clk), .reset(reset), .mv_valid(bus.mv_valid), .d(bus.dy), .pos(pos_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld    <= 1'b0;
            s1_btn    <= '0;
            btn_q     <= '0;
            pos_upd_q <= 1'b0;
            click_q   <= 1'b0;
        end else begin
            s1_vld    <= bus.mv_valid;
            if (bus.mv_valid)
                s1_btn <= bus.btn_in;
            pos_upd_q <= s1_vld;
            click_q   <= s1_vld & s1_btn[0] & ~btn_q[0];
            if (s1_vld)
                btn_q <= s1_btn;
        end
    end

    assign bus.pos_x   = pos_x;
    assign bus.pos_y   = pos_y;
    assign bus.btn     = btn_q;
    assign bus.pos_upd = pos_upd_q;
    assign bus.click_l = click_q;

`ifdef CURSOR_GRID_EN
    logic [1:0] cell_col_q;
    logic [1:0] cell_row_q;
    logic       cell_vld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cell_col_q <= OUTSIDE;
            cell_row_q <= OUTSIDE;
            cell_vld_q <= 1'b0;
        end else begin
            cell_vld_q <= pos_upd_q;
            if (pos_upd_q) begin
                cell_col_q <= cell_of(calc_t'({1'b0, pos_x}), calc_t'(GRID_X0), calc_t'(CELL_W));
                cell_row_q <= cell_of(calc_t'({1'b0, pos_y}), calc_t'(GRID_Y0), calc_t'(CELL_H));
            end
        end
    end

    assign bus.cell_col = cell_col_q;
    assign bus.cell_row = cell_row_q;
    assign bus.cell_vld = cell_vld_q;
`endif
endmodule

// File: tb/tb_cursor_tracker.sv
// Directed self-checking bench for cursor_tracker; grid checks are included
// when CURSOR_GRID_EN is defined.
module tb_cursor_tracker;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cursor_tracker_if #(.POS_W(10)) bus ();

    cursor_tracker dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one packet, check the update cycle, then check the pulse drops.
    task automatic pkt(input string tag, input int x, input int y, input logic [2:0] b,
                       input int ex, input int ey, input logic ec);
        bus.mv_valid = 1'b1;
        bus.dx       = 9'(x);
        bus.dy       = 9'(y);
        bus.btn_in   = b;
        tick();
        bus.mv_valid = 1'b0;
        bus.dx       = '0;
        bus.dy       = '0;
        bus.btn_in   = '0;
        tick();
        chk({tag, ".upd"},   32'(bus.pos_upd), 1);
        chk({tag, ".x"},     32'(bus.pos_x),   32'(ex));
        chk({tag, ".y"},     32'(bus.pos_y),   32'(ey));
        chk({tag, ".btn"},   32'(bus.btn),     32'(b));
        chk({tag, ".click"}, 32'(bus.click_l), 32'(ec));
        tick();
        chk({tag, ".upd_off"},   32'(bus.pos_upd), 0);
        chk({tag, ".click_off"}, 32'(bus.click_l), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mv_valid = 1'b0;
        bus.dx       = '0;
        bus.dy       = '0;
        bus.btn_in   = '0;

        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("rst.x",     32'(bus.pos_x),   20);
        chk("rst.y",     32'(bus.pos_y),   240);
        chk("rst.btn",   32'(bus.btn),     0);
        chk("rst.upd",   32'(bus.pos_upd), 0);
        chk("rst.click", 32'(bus.click_l), 0);
`ifdef CURSOR_GRID_EN
        chk("rst.col",   32'(bus.cell_col), 3);
        chk("rst.row",   32'(bus.cell_row), 3);
        chk("rst.cvld",  32'(bus.cell_vld), 0);
`endif

        pkt("small",  5,    3,    3'b000, 25,  237, 1'b0);
        pkt("x2",     20,   0,    3'b000, 65,  237, 1'b0);
        pkt("clamp",  -100, -256, 3'b000, 0,   475, 1'b0);
        pkt("wall",   -1,   -1,   3'b000, 0,   475, 1'b0);

        pkt("b0", 0, 0, 3'b000, 0, 475, 1'b0);
        pkt("b1", 0, 0, 3'b001, 0, 475, 1'b1);
        pkt("b2", 0, 0, 3'b011, 0, 475, 1'b0);
        pkt("b3", 0, 0, 3'b000, 0, 475, 1'b0);
        pkt("b4", 0, 0, 3'b001, 0, 475, 1'b1);

        // Packet in flight when reset hits must vanish
        bus.mv_valid = 1'b1;
        bus.dx       = 9'(5);
        bus.btn_in   = 3'b001;
        tick();
        bus.mv_valid = 1'b0;
        bus.dx       = '0;
        bus.btn_in   = '0;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
        chk("flush.x",   32'(bus.pos_x),   20);
        chk("flush.y",   32'(bus.pos_y),   240);
        chk("flush.btn", 32'(bus.btn),     0);
        chk("flush.upd", 32'(bus.pos_upd), 0);
        tick();
        chk("flush.upd2",   32'(bus.pos_upd), 0);
        chk("flush.click2", 32'(bus.click_l), 0);
        chk("flush.x2",     32'(bus.pos_x),   20);

        pkt("rclick", 0, 0, 3'b001, 20, 240, 1'b1);
        pkt("hold",   0, 8, 3'b001, 20, 224, 1'b0);

        bus.mv_valid = 1'b1;
        bus.dx       = 9'(1);
        bus.dy       = '0;
        bus.btn_in   = '0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c >= 2) begin
                chk($sformatf("b2b%0d.upd", c), 32'(bus.pos_upd), (c <= 5) ? 1 : 0);
                chk($sformatf("b2b%0d.x", c),   32'(bus.pos_x),   (c <= 5) ? 19 + c : 24);
                chk($sformatf("b2b%0d.y", c),   32'(bus.pos_y),   224);
            end
            if (c == 4) begin
                bus.mv_valid = 1'b0;
                bus.dx       = '0;
            end
        end

        pkt("t1_edge", 7,   0, 3'b000, 31,  224, 1'b0);
        pkt("t2_lo",   8,   0, 3'b000, 47,  224, 1'b0);
        pkt("t2_hi",   63,  0, 3'b000, 173, 224, 1'b0);
        pkt("t4_lo",   64,  0, 3'b000, 429, 224, 1'b0);
        pkt("xmax",    127, 0, 3'b000, 630, 224, 1'b0);
        pkt("xwall",   8,   0, 3'b000, 630, 224, 1'b0);

`ifdef CURSOR_GRID_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("grst.col", 32'(bus.cell_col), 3);
        chk("grst.row", 32'(bus.cell_row), 3);
        pkt("g0", 0, 0, 3'b000, 20, 240, 1'b0);
        chk("g0.cvld", 32'(bus.cell_vld), 1);
        chk("g0.col",  32'(bus.cell_col), 3);
        chk("g0.row",  32'(bus.cell_row), 1);
        pkt("g1", 63, 0,  3'b000, 146, 240, 1'b0);
        pkt("g2", 32, 0,  3'b000, 210, 240, 1'b0);
        pkt("g3", 32, 0,  3'b000, 274, 240, 1'b0);
        pkt("g4", 1,  20, 3'b000, 275, 200, 1'b0);
        pkt("g5", 0,  5,  3'b000, 275, 195, 1'b0);
        chk("g5.cvld", 32'(bus.cell_vld), 1);
        chk("g5.col",  32'(bus.cell_col), 1);
        chk("g5.row",  32'(bus.cell_row), 1);
        tick();
        chk("g5.cvld_off", 32'(bus.cell_vld), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
